hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Producer-side companion to the pipeline bypass network: stalls, bubbles and flushes the pipeline whenever forwarding cannot resolve a hazard.
- Covers three cases: load-use hazards, multi-cycle mult/div occupancy and taken-branch/jump flushes.
- Sits beside the bypass logic, reads the F/D and D/X instruction latches, and drives latch write-enables and nop-injection muxes.

Parameters:
- MD_TIMEOUT, 64, max BUSY cycles before a mult/div is aborted.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- IR_FD  in  32  instruction in F/D latch
- IR_DX  in  32  instruction in D/X latch
- multdiv_rdy  in  1  mult/div result valid pulse
- branch_taken  in  1  branch/jump/jr redirect resolved in X this cycle
- stall_pc  out  1  hold PC
- stall_fd  out  1  hold F/D latch
- stall_dx  out  1  hold D/X latch
- bubble_dx  out  1  load nop into D/X
- bubble_xm  out  1  load nop into X/M
- flush_fd  out  1  load nop into F/D
- md_start  out  1  one-cycle ctrl_MULT/ctrl_DIV launch
- md_is_div  out  1  0=mul, 1=div for current op
- md_result_we  out  1  capture mult/div result into X/M
- md_exception  out  1  one-cycle pulse on timeout
- stall_count  out  CNT_W  saturating count of stall_pc cycles

Behaviour:
- Field decode:
  - opcode [31:27], rd [26:22], rs [21:17], rt [16:12], aluop [6:2].
  - Opcodes: R-type 00000, lw 01000, sw 00111, bne 00010, blt 00110, jr 00100.
  - R-type mul aluop 00110, div 00111.
- Reset: all outputs 0, FSM=IDLE, internal timer=0, stall_count=0.
- Load-use (combinational, IDLE only):
  - Condition: IR_DX is lw with rd!=0, and IR_FD reads that register.
  - Sources read by IR_FD by opcode:
    - R-type: rs, rt.
    - sw: rs, rd.
    - bne/blt: rd, rs.
    - jr: rd.
    - all other opcodes: rs.
  - Action: stall_pc=stall_fd=bubble_dx=1 for exactly one cycle. The next cycle, lw sits in X/M and the bypass path resolves it.
- Branch flush (IDLE only): branch_taken → flush_fd=1, bubble_dx=1. This takes priority over load-use: stall_pc=stall_fd=0, so the redirect is accepted.
- FSM states: IDLE, ISSUE, BUSY, DONE.
  - IDLE→ISSUE: IR_DX is R-type mul/div and branch_taken=0.
  - ISSUE (1 cycle): md_start=1; md_is_div latched from aluop; stall_pc=stall_fd=stall_dx=1, bubble_xm=1; timer cleared; →BUSY.
  - BUSY:
    - Same stall/bubble set every cycle; timer increments.
    - multdiv_rdy=1 → DONE.
    - Timer reaches MD_TIMEOUT-1 with no rdy → md_exception=1 for one cycle, →IDLE, bubble_xm=1 that cycle.
  - DONE (1 cycle): md_result_we=1; stall_pc=stall_fd=stall_dx=0, bubble_xm=0; →IDLE. The D/X instruction advances with its result.
  - multdiv_rdy outside BUSY: ignored.
  - branch_taken outside IDLE: ignored. A mul/div in DX implies no branch in X.
- Simultaneity: ISSUE stalls override load-use; no load-use bubble is issued while FSM≠IDLE.
- stall_count: +1 on each cycle with stall_pc=1; saturates at all-ones.
- Reset mid-BUSY: FSM→IDLE next edge, all stalls drop, md_result_we not asserted.
- Latency:
  - Load-use penalty = 1 cycle.
  - Mul/div penalty = rdy latency + 2 (ISSUE + DONE).
  - Branch penalty = 2 bubbles.

Test Plan:
- lw r5 in DX, add r6,r5,r7 in FD → one cycle stall_pc=stall_fd=bubble_dx=1, then all 0; stall_count=1.
- lw r0 in DX, add r6,r0,r0 in FD → no stall; lw r5 in DX, sw r5,0(r2) in FD → stall (rd source).
- mul in DX, multdiv_rdy after 8 cycles → md_start one pulse, stalls held 1+8 cycles, md_result_we one pulse in DONE, stall_count=9.
- div in DX, rdy never asserted → md_exception pulses at cycle MD_TIMEOUT of BUSY, FSM IDLE, md_is_div=1 during op.
- branch_taken=1 while load-use condition is true → flush_fd=bubble_dx=1, stall_pc=0.
- reset asserted in BUSY cycle 3 → next cycle all outputs 0, later rdy ignored, stall_count=0.

Source files
------------

// File: rtl/hazard_stall_unit_if.sv
// Pipeline hazard control bundle: latch instructions and mult/div status in,
// stall, bubble, flush and mult/div control out.
interface hazard_stall_unit_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      IR_FD;
    logic [31:0]      IR_DX;
    logic             multdiv_rdy;
    logic             branch_taken;
    logic             stall_pc;
    logic             stall_fd;
    logic             stall_dx;
    logic             bubble_dx;
    logic             bubble_xm;
    logic             flush_fd;
    logic             md_start;
    logic             md_is_div;
    logic             md_result_we;
    logic             md_exception;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output IR_FD, IR_DX, multdiv_rdy, branch_taken,
        input  stall_pc, stall_fd, stall_dx, bubble_dx, bubble_xm,
        input  flush_fd, md_start, md_is_div, md_result_we,
        input  md_exception, stall_count
    );

    modport slave (
        input  IR_FD, IR_DX, multdiv_rdy, branch_taken,
        output stall_pc, stall_fd, stall_dx, bubble_dx, bubble_xm,
        output flush_fd, md_start, md_is_div, md_result_we,
        output md_exception, stall_count
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Stall/bubble/flush control for hazards the bypass network cannot resolve:
// load-use, multi-cycle mult/div occupancy and taken-branch redirects.
module hazard_stall_unit #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input logic          clock,
    input logic          reset,
    hazard_stall_unit_if.slave hs
);
    localparam int TW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(MD_TIMEOUT - 1);

    localparam logic [4:0] OP_R   = 5'b00000;
    localparam logic [4:0] OP_LW  = 5'b01000;
    localparam logic [4:0] OP_SW  = 5'b00111;
    localparam logic [4:0] OP_BNE = 5'b00010;
    localparam logic [4:0] OP_BLT = 5'b00110;
    localparam logic [4:0] OP_JR  = 5'b00100;
    localparam logic [4:0] AL_MUL = 5'b00110;
    localparam logic [4:0] AL_DIV = 5'b00111;

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             is_div_q, is_div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [4:0] op_fd, rd_fd, rs_fd, rt_fd;
    logic [4:0] op_dx, rd_dx, alu_dx;
    logic       use_rs, use_rt, use_rd;
    logic       load_use, dx_md, timeout;

    logic stall_pc, stall_fd, stall_dx;
    logic bubble_dx, bubble_xm, flush_fd;
    logic md_start, md_result_we, md_exception;

    assign op_fd  = hs.IR_FD[31:27];
    assign rd_fd  = hs.IR_FD[26:22];
    assign rs_fd  = hs.IR_FD[21:17];
    assign rt_fd  = hs.IR_FD[16:12];
    assign op_dx  = hs.IR_DX[31:27];
    assign rd_dx  = hs.IR_DX[26:22];
    assign alu_dx = hs.IR_DX[6:2];

    // Register sources actually read by the F/D instruction
    always_comb begin
        use_rs = 1'b0;
        use_rt = 1'b0;
        use_rd = 1'b0;
        unique case (op_fd)
            OP_R: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            OP_SW, OP_BNE, OP_BLT: begin
                use_rs = 1'b1;
                use_rd = 1'b1;
            end
            OP_JR:   use_rd = 1'b1;
            default: use_rs = 1'b1;
        endcase
    end

    always_comb begin
        load_use = (op_dx == OP_LW) && (rd_dx != 5'd0)
                && ((use_rs && rs_fd == rd_dx)
                 || (use_rt && rt_fd == rd_dx)
                 || (use_rd && rd_fd == rd_dx));
        dx_md    = (op_dx == OP_R)
                && (alu_dx == AL_MUL || alu_dx == AL_DIV);
        timeout  = (state_q == BUSY) && !hs.multdiv_rdy
                && (timer_q == T_LAST);
    end

    always_comb begin
        stall_pc     = 1'b0;
        stall_fd     = 1'b0;
        stall_dx     = 1'b0;
        bubble_dx    = 1'b0;
        bubble_xm    = 1'b0;
        flush_fd     = 1'b0;
        md_start     = 1'b0;
        md_result_we = 1'b0;
        md_exception = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Redirect wins so the new PC is accepted this cycle
                if (hs.branch_taken) begin
                    flush_fd  = 1'b1;
                    bubble_dx = 1'b1;
                end else if (load_use) begin
                    stall_pc  = 1'b1;
                    stall_fd  = 1'b1;
                    bubble_dx = 1'b1;
                end
            end
            ISSUE: begin
                stall_pc  = 1'b1;
                stall_fd  = 1'b1;
                stall_dx  = 1'b1;
                bubble_xm = 1'b1;
                md_start  = 1'b1;
            end
            BUSY: begin
                stall_pc     = 1'b1;
                stall_fd     = 1'b1;
                stall_dx     = 1'b1;
                bubble_xm    = 1'b1;
                md_exception = timeout;
            end
            DONE:    md_result_we = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        is_div_d = is_div_q;
        unique case (state_q)
            IDLE: begin
                if (dx_md && !hs.branch_taken) begin
                    state_d  = ISSUE;
                    is_div_d = (alu_dx == AL_DIV);
                end
            end
            ISSUE: begin
                state_d = BUSY;
                timer_d = '0;
            end
            BUSY: begin
                if (hs.multdiv_rdy)
                    state_d = DONE;
                else if (timeout)
                    state_d = IDLE;
                else
                    timer_d = timer_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall_pc && cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            is_div_q <= is_div_d;
            cnt_q    <= cnt_d;
        end
    end

    assign hs.stall_pc     = stall_pc;
    assign hs.stall_fd     = stall_fd;
    assign hs.stall_dx     = stall_dx;
    assign hs.bubble_dx    = bubble_dx;
    assign hs.bubble_xm    = bubble_xm;
    assign hs.flush_fd     = flush_fd;
    assign hs.md_start     = md_start;
    assign hs.md_is_div    = is_div_q && (state_q != IDLE);
    assign hs.md_result_we = md_result_we;
    assign hs.md_exception = md_exception;
    assign hs.stall_count  = cnt_q;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed scoreboard bench for hazard_stall_unit: each step pushes the
// expected outputs and stall count, then pops and checks them mid-cycle.
module tb_hazard_stall_unit;
    localparam int TO = 16;
    localparam int CW = 4;

    // bit order: stall_pc stall_fd stall_dx bubble_dx bubble_xm
    //            flush_fd md_start md_is_div md_result_we md_exception
    localparam logic [9:0] NONE   = 10'b0000000000;
    localparam logic [9:0] LU     = 10'b1101000000;
    localparam logic [9:0] BR     = 10'b0001010000;
    localparam logic [9:0] ISS_M  = 10'b1110101000;
    localparam logic [9:0] ISS_D  = 10'b1110101100;
    localparam logic [9:0] BSY_M  = 10'b1110100000;
    localparam logic [9:0] BSY_D  = 10'b1110100100;
    localparam logic [9:0] DONE_M = 10'b0000000010;
    localparam logic [9:0] TMO_D  = 10'b1110100101;

    typedef struct packed {
        logic [9:0]    v;
        logic [CW-1:0] c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic [CW-1:0] cnt_m = '0;
    exp_t exp_q[$];

    hazard_stall_unit_if #(.CNT_W(CW)) hs ();

    hazard_stall_unit #(.MD_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clock(clk),
        .reset(rst),
        .hs   (hs.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rt_i(input logic [4:0] rd, rs, rt, alu);
        return {5'b00000, rd, rs, rt, 5'b00000, alu, 2'b00};
    endfunction

    function automatic logic [31:0] it_i(input logic [4:0] op, rd, rs, rt);
        return {op, rd, rs, rt, 12'h000};
    endfunction

    function automatic logic [9:0] obs();
        return {hs.stall_pc, hs.stall_fd, hs.stall_dx, hs.bubble_dx,
                hs.bubble_xm, hs.flush_fd, hs.md_start, hs.md_is_div,
                hs.md_result_we, hs.md_exception};
    endfunction

    task automatic step(input string tag, input logic r,
                        input logic [31:0] fd, input logic [31:0] dx,
                        input logic rdy, input logic br,
                        input logic [9:0] e);
        exp_t x;
        exp_t g;
        @(posedge clk);
        #1;
        rst             = r;
        hs.IR_FD        = fd;
        hs.IR_DX        = dx;
        hs.multdiv_rdy  = rdy;
        hs.branch_taken = br;
        x.v = e;
        x.c = cnt_m;
        exp_q.push_back(x);
        if (r)
            cnt_m = '0;
        else if (e[9] && cnt_m != {CW{1'b1}})
            cnt_m = cnt_m + 1'b1;
        @(negedge clk);
        g = exp_q.pop_front();
        tests++;
        assert (obs() === g.v) else begin
            fails++;
            $error("FAIL %s outputs got %b want %b", tag, obs(), g.v);
        end
        tests++;
        assert (hs.stall_count === g.c) else begin
            fails++;
            $error("FAIL %s stall_count got %0d want %0d",
                   tag, hs.stall_count, g.c);
        end
    endtask

    logic [31:0] nop, lw5, lw0, add5, add0, sw5, bne5, jr5, oth5;
    logic [31:0] mul, dv;

    initial begin
        nop  = 32'h0;
        lw5  = it_i(5'b01000, 5'd5, 5'd2, 5'd0);
        lw0  = it_i(5'b01000, 5'd0, 5'd2, 5'd0);
        add5 = rt_i(5'd6, 5'd5, 5'd7, 5'b00000);
        add0 = rt_i(5'd6, 5'd0, 5'd0, 5'b00000);
        sw5  = it_i(5'b00111, 5'd5, 5'd2, 5'd0);
        bne5 = it_i(5'b00010, 5'd5, 5'd1, 5'd0);
        jr5  = it_i(5'b00100, 5'd3, 5'd5, 5'd5);
        oth5 = it_i(5'b00101, 5'd5, 5'd1, 5'd5);
        mul  = rt_i(5'd4, 5'd1, 5'd2, 5'b00110);
        dv   = rt_i(5'd4, 5'd1, 5'd2, 5'b00111);
        hs.IR_FD        = nop;
        hs.IR_DX        = nop;
        hs.multdiv_rdy  = 1'b0;
        hs.branch_taken = 1'b0;
        repeat (2) @(posedge clk);

        step("reset",    1, nop,  nop, 0, 0, NONE);
        step("idle",     0, nop,  nop, 0, 0, NONE);
        step("lu_add",   0, add5, lw5, 0, 0, LU);
        step("lu_after", 0, add5, nop, 0, 0, NONE);
        step("lw_r0",    0, add0, lw0, 0, 0, NONE);
        step("lu_sw",    0, sw5,  lw5, 0, 0, LU);
        step("sw_after", 0, sw5,  nop, 0, 0, NONE);
        step("lu_bne",   0, bne5, lw5, 0, 0, LU);
        step("bne_aft",  0, bne5, nop, 0, 0, NONE);
        step("jr_rs",    0, jr5,  lw5, 0, 0, NONE);
        step("oth_rd",   0, oth5, lw5, 0, 0, NONE);
        step("br_lu",    0, add5, lw5, 0, 1, BR);
        step("rdy_idle", 0, nop,  nop, 1, 0, NONE);
        step("br_md",    0, nop,  mul, 0, 1, BR);
        step("br_md2",   0, nop,  nop, 0, 0, NONE);

        step("mul_det",  0, nop,  mul, 0, 0, NONE);
        step("mul_iss",  0, nop,  mul, 0, 0, ISS_M);
        for (int k = 1; k <= 8; k++)
            step("mul_busy", 0, add5, mul, k == 8, k == 2, BSY_M);
        step("mul_done", 0, nop,  mul, 0, 0, DONE_M);
        step("mul_post", 0, nop,  nop, 0, 0, NONE);

        step("div_det",  0, nop,  dv,  0, 0, NONE);
        step("div_iss",  0, nop,  dv,  0, 0, ISS_D);
        for (int k = 1; k <= TO; k++)
            step("div_busy", 0, nop, dv, 0, 0, (k == TO) ? TMO_D : BSY_D);
        step("div_post", 0, nop,  nop, 1, 0, NONE);
        step("sat_hold", 0, nop,  nop, 0, 0, NONE);

        step("rb_det",   0, nop,  mul, 0, 0, NONE);
        step("rb_iss",   0, nop,  mul, 0, 0, ISS_M);
        step("rb_b1",    0, nop,  mul, 0, 0, BSY_M);
        step("rb_b2",    0, nop,  mul, 0, 0, BSY_M);
        step("rb_b3rst", 1, nop,  mul, 0, 0, BSY_M);
        step("rb_post",  0, nop,  nop, 1, 0, NONE);
        step("rb_rdy",   0, nop,  nop, 1, 0, NONE);
        step("rb_idle",  0, nop,  nop, 0, 0, NONE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
